// File: rtl/cv32e40p_instr_aligner.sv
// Instruction aligner: turns word-aligned prefetch FIFO entries into one
// RV32IC instruction per transfer. It splits words that hold compressed
// instructions and stitches 32-bit instructions that straddle two words.
module cv32e40p_instr_aligner #(
  parameter bit ERR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        fetch_pop_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic        instr_compressed_o,
  output logic        instr_err_o,
  output logic [31:0] pc_o,
  input  logic        if_valid_i
);

  typedef enum logic [1:0] {
    StAligned32,
    StMisaligned32,
    StBranchMisaligned
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // Upper half of the most recently popped word and its error flag
  logic [15:0] r_h_q, r_h_d;
  logic        r_err_q, r_err_d;

  logic [15:0] lo_h, hi_h;
  logic        lo_is32, hi_is32, rh_is32;
  logic        err;

  assign lo_h    = fetch_rdata_i[15:0];
  assign hi_h    = fetch_rdata_i[31:16];
  assign lo_is32 = (lo_h[1:0] == 2'b11);
  assign hi_is32 = (hi_h[1:0] == 2'b11);
  assign rh_is32 = (r_h_q[1:0] == 2'b11);

  assign pc_o = pc_q;

  // Next-state and output decode; a redirect overrides everything the FSM decided
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    r_h_d              = r_h_q;
    r_err_d            = r_err_q;
    instr_valid_o      = 1'b0;
    fetch_pop_o        = 1'b0;
    instr_o            = fetch_rdata_i;
    instr_compressed_o = 1'b0;
    err                = 1'b0;

    case (state_q)
      StAligned32: begin
        instr_valid_o = fetch_valid_i;
        err           = fetch_err_i;
        if (lo_is32) begin
          instr_o = fetch_rdata_i;
        end else begin
          instr_o            = {16'h0000, lo_h};
          instr_compressed_o = 1'b1;
        end
        if (fetch_valid_i && if_valid_i) begin
          fetch_pop_o = 1'b1;
          if (lo_is32) begin
            pc_d = pc_q + 32'd4;
          end else begin
            // Upper half becomes the start of the next instruction
            pc_d    = pc_q + 32'd2;
            r_h_d   = hi_h;
            r_err_d = fetch_err_i;
            state_d = StMisaligned32;
          end
        end
      end

      StMisaligned32: begin
        if (rh_is32) begin
          // Straddling instruction: low half held, high half from the head word
          instr_o       = {lo_h, r_h_q};
          instr_valid_o = fetch_valid_i;
          err           = r_err_q | fetch_err_i;
          if (fetch_valid_i && if_valid_i) begin
            fetch_pop_o = 1'b1;
            r_h_d       = hi_h;
            r_err_d     = fetch_err_i;
            pc_d        = pc_q + 32'd4;
          end
        end else begin
          // Held compressed instruction needs nothing from the FIFO
          instr_o            = {16'h0000, r_h_q};
          instr_compressed_o = 1'b1;
          instr_valid_o      = 1'b1;
          err                = r_err_q;
          if (if_valid_i) begin
            pc_d    = pc_q + 32'd2;
            state_d = StAligned32;
          end
        end
      end

      StBranchMisaligned: begin
        // Target sits in the upper half; the lower half is discarded
        if (hi_is32) begin
          if (fetch_valid_i) begin
            fetch_pop_o = 1'b1;
            r_h_d       = hi_h;
            r_err_d     = fetch_err_i;
            state_d     = StMisaligned32;
          end
        end else begin
          instr_o            = {16'h0000, hi_h};
          instr_compressed_o = 1'b1;
          instr_valid_o      = fetch_valid_i;
          err                = fetch_err_i;
          if (fetch_valid_i && if_valid_i) begin
            fetch_pop_o = 1'b1;
            pc_d        = pc_q + 32'd2;
            state_d     = StAligned32;
          end
        end
      end

      default: begin
        state_d = StAligned32;
      end
    endcase

    if (branch_i) begin
      instr_valid_o = 1'b0;
      fetch_pop_o   = 1'b0;
      pc_d          = branch_addr_i;
      r_h_d         = 16'h0000;
      r_err_d       = 1'b0;
      state_d       = branch_addr_i[1] ? StBranchMisaligned : StAligned32;
    end

    if (rst_i) begin
      instr_valid_o = 1'b0;
      fetch_pop_o   = 1'b0;
    end

    instr_err_o = ERR_EN ? err : 1'b0;
  end

  // State registers with synchronous reset to the boot address
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= boot_addr_i[1] ? StBranchMisaligned : StAligned32;
      pc_q    <= boot_addr_i;
      r_h_q   <= 16'h0000;
      r_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      r_h_q   <= r_h_d;
      r_err_q <= ERR_EN ? r_err_d : 1'b0;
    end
  end

endmodule

// File: doc/cv32e40p_instr_aligner.md
Name: cv32e40p_instr_aligner

Overview:
Downstream consumer of the prefetch FIFO. It takes 32-bit word-aligned fetch words from the FIFO head and produces one RV32IC instruction per accepted cycle, with its PC, to the IF/ID stage. It splits words holding compressed instructions and stitches 32-bit instructions that straddle two words. It forwards the FIFO per-entry parity error with each instruction.

Parameters:
ERR_EN, 1, when 1 instr_err_o reflects fetch_err_i of every consumed half-word; when 0 instr_err_o is tied 0.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
boot_addr_i  in  32  initial PC, sampled while rst_i=1; bit 0 must be 0
fetch_valid_i  in  1  FIFO not empty (~empty_o of FIFO)
fetch_rdata_i  in  32  FIFO head word (data_o), always from a word-aligned address
fetch_err_i  in  1  parity error flag for the head word
fetch_pop_o  out  1  pop FIFO head this cycle; only asserted when fetch_valid_i=1
branch_i  in  1  redirect; FIFO is flushed externally in the same cycle
branch_addr_i  in  32  redirect target, bit 0 = 0
instr_valid_o  out  1  instr_o/pc_o valid
instr_o  out  32  instruction; compressed instructions are zero-extended to {16'h0, c}
instr_compressed_o  out  1  instr_o[15:0] is a 16-bit instruction
instr_err_o  out  1  OR of error flags of the half-words forming instr_o
pc_o  out  32  address of instr_o
if_valid_i  in  1  downstream accepts instr_o this cycle (transfer = instr_valid_o & if_valid_i)

Behaviour:
- State: FSM {ALIGNED32, MISALIGNED32, BRANCH_MISALIGNED}; pc_q[31:0]; r_h[15:0] upper half of last popped word; r_err.
- Reset (rst_i=1 at edge): pc_q<=boot_addr_i; state<=ALIGNED32 if boot_addr_i[1]=0 else BRANCH_MISALIGNED; r_h<=0; r_err<=0. During reset, outputs are derived from reset state; instr_valid_o=0 and fetch_pop_o=0 while rst_i=1.
- Combinational outputs, zero latency from fetch inputs. pc_o=pc_q. Holding: no state changes without a transfer, so outputs stay stable while instr_valid_o=1 and if_valid_i=0.
- "32-bit" means half[1:0]==2'b11; otherwise compressed. PC arithmetic is modulo 2^32 and wraps 0xFFFFFFFE+2 -> 0.
- ALIGNED32, head word w:
  - w[1:0]==11: instr=w, valid=fetch_valid_i. On transfer: pop, pc+=4, stay.
  - Compressed: instr={0,w[15:0]}, valid=fetch_valid_i. On transfer: pop, r_h<=w[31:16], r_err<=fetch_err_i, pc+=2, go to MISALIGNED32.
- MISALIGNED32 (pc_q[1]=1):
  - r_h[1:0]==11: instr={w[15:0],r_h}, valid=fetch_valid_i, err=r_err|fetch_err_i. On transfer: pop, r_h<=w[31:16], r_err<=fetch_err_i, pc+=4, stay.
  - Compressed: instr={0,r_h}, valid=1 regardless of fetch_valid_i, err=r_err, no pop. On transfer: pc+=2, go to ALIGNED32.
- BRANCH_MISALIGNED (target half-word is w[31:16]; w[15:0] is discarded):
  - w[17:16]==11: valid=0. If fetch_valid_i: pop, r_h<=w[31:16], r_err<=fetch_err_i, go to MISALIGNED32, pc unchanged.
  - Compressed: instr={0,w[31:16]}, valid=fetch_valid_i. On transfer: pop, pc+=2, go to ALIGNED32.
- branch_i=1 has highest priority over all state activity: instr_valid_o=0, fetch_pop_o=0, pc_q<=branch_addr_i, r_err<=0. Next state is ALIGNED32 if branch_addr_i[1]=0, else BRANCH_MISALIGNED. Any half-instruction held in r_h is dropped.
- Reset and branch in the same cycle: reset wins.
- fetch_pop_o is never asserted with fetch_valid_i=0. A pop happens at most once per cycle.
- ERR_EN=0: instr_err_o=0 and r_err is unused.

Test Plan:
- Reset with boot_addr_i=0x80; FIFO supplies 0x00000013, 0x00100093 with if_valid_i=1 -> two transfers at pc 0x80 and 0x84, instr_compressed_o=0, two pops.
- Word 0x4501_4505 (two compressed) -> transfer instr 0x00004505 pc 0x80 with pop, then instr 0x00004501 pc 0x82 with fetch_valid_i=0, no pop, state back to ALIGNED32.
- Straddle: words 0x0013_4505, then 0x0093_0000 -> 0x4505 @0x80, then instr 0x00000013 @0x82 assembled from two words with fetch_err_i=1 on the second word only -> instr_err_o=1.
- Branch to 0x102 with head word 0x4585_xxxx -> first instr 0x00004585 pc 0x102. Branch to 0x106 with word 0x0513_xxxx then 0x0000_0000 -> no valid until the second word, then instr 0x00000513 @0x106.
- Backpressure: instr_valid_o=1 with if_valid_i=0 for 5 cycles -> instr_o, pc_o and state constant, fetch_pop_o=0 throughout.
- branch_i in MISALIGNED32 mid-straddle, and rst_i together with branch_i -> r_h discarded and pc=branch_addr_i. With both asserted, pc=boot_addr_i, valid=0 that cycle.
